// File: rtl/sand_brush_painter.sv
// -----------------------------------------------------------------------------
// sand_brush_painter
//
// Purpose:
//   Takes a brush command (centre x/y, radius, particle type) and rasterises a
//   filled disc of that particle type into the sand cell buffer. It issues one
//   cell write per cycle through a ready/valid style write port. The box around
//   the disc is clipped to the grid, so coordinates never wrap.
//
// Ports:
//   clock         in   1       system clock, rising edge
//   reset         in   1       synchronous, active-high
//   start         in   1       one-cycle request to paint the current brush
//   brush_x       in   8       disc centre column
//   brush_y       in   8       disc centre row
//   brush_radius  in   8       disc radius in cells
//   brush_type    in   2       particle type written to each covered cell
//   busy          out  1       high whenever the FSM is not idle
//   done          out  1       one-cycle pulse when a paint completes
//   cell_addr     out  ADDR_W  write address = cy*GRID_W + cx
//   cell_data     out  2       write data = latched brush type
//   cell_we       out  1       write request; transfer when cell_we && cell_ready
//   cell_ready    in   1       buffer accepts the write this cycle
//
// Configuration:
//   BRUSH_SQUARE_EN  when defined, the distance test is removed and every cell
//                    of the clipped bounding box is written (square brush).
// -----------------------------------------------------------------------------
module sand_brush_painter #(
  parameter int GRID_W = 160,
  parameter int GRID_H = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        brush_x,
  input  logic [7:0]        brush_y,
  input  logic [7:0]        brush_radius,
  input  logic [1:0]        brush_type,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cell_addr,
  output logic [1:0]        cell_data,
  output logic              cell_we,
  input  logic              cell_ready
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCAN,
    ST_DONE
  } state_t;

  localparam logic signed [9:0] X_MAX = 10'(GRID_W - 1);
  localparam logic signed [9:0] Y_MAX = 10'(GRID_H - 1);

  state_t state, next_state;

  logic [7:0] x_q, y_q, r_q;
  logic [1:0] type_q;
  logic [7:0] x0_q, x1_q, y1_q;
  logic [7:0] cx, cy;

  logic signed [9:0] lo_x, hi_x, lo_y, hi_y;
  logic [7:0]        x0, x1, y0, y1;
  logic              box_empty;
  logic              in_disc;
  logic              advance;
  logic              last_cell;

  // Bounding box in signed 10-bit so that x-r can go negative and x+r can
  // exceed 255 without wrapping; results are then clamped onto the grid.
  always_comb begin
    lo_x      = $signed({2'b00, x_q}) - $signed({2'b00, r_q});
    hi_x      = $signed({2'b00, x_q}) + $signed({2'b00, r_q});
    lo_y      = $signed({2'b00, y_q}) - $signed({2'b00, r_q});
    hi_y      = $signed({2'b00, y_q}) + $signed({2'b00, r_q});
    x0        = lo_x[9] ? 8'd0 : lo_x[7:0];
    y0        = lo_y[9] ? 8'd0 : lo_y[7:0];
    x1        = (hi_x > X_MAX) ? X_MAX[7:0] : hi_x[7:0];
    y1        = (hi_y > Y_MAX) ? Y_MAX[7:0] : hi_y[7:0];
    box_empty = (lo_x > X_MAX) || (lo_y > Y_MAX);
  end

`ifdef BRUSH_SQUARE_EN
  assign in_disc = 1'b1;
`else
  logic [15:0]       r2_q;
  logic signed [8:0] dx, dy;
  logic [7:0]        adx, ady;
  logic [15:0]       dx2, dy2;
  logic [16:0]       d2;

  // Squaring magnitudes keeps the multipliers unsigned 8x8; |dx| never
  // exceeds 255 because cx is on-grid and x is 8-bit.
  always_comb begin
    dx  = $signed({1'b0, cx}) - $signed({1'b0, x_q});
    dy  = $signed({1'b0, cy}) - $signed({1'b0, y_q});
    adx = dx[8] ? 8'(-dx) : dx[7:0];
    ady = dy[8] ? 8'(-dy) : dy[7:0];
    dx2 = 16'(adx) * 16'(adx);
    dy2 = 16'(ady) * 16'(ady);
    d2  = {1'b0, dx2} + {1'b0, dy2};
    in_disc = (d2 <= {1'b0, r2_q});
  end
`endif

  // A covered cell waits for the buffer; an uncovered cell is skipped at once.
  assign cell_we   = (state == ST_SCAN) && in_disc;
  assign advance   = (state == ST_SCAN) && (!in_disc || cell_ready);
  assign last_cell = (cx == x1_q) && (cy == y1_q);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign cell_data = type_q;
  assign cell_addr = ADDR_W'(cy) * ADDR_W'(GRID_W) + ADDR_W'(cx);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = ST_SETUP;
      ST_SETUP: next_state = box_empty ? ST_DONE : ST_SCAN;
      ST_SCAN:  if (advance && last_cell) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Command latch, box registers and raster counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      r_q    <= '0;
      type_q <= '0;
      x0_q   <= '0;
      x1_q   <= '0;
      y1_q   <= '0;
      cx     <= '0;
      cy     <= '0;
`ifndef BRUSH_SQUARE_EN
      r2_q   <= '0;
`endif
    end else begin
      if (state == ST_IDLE && start) begin
        x_q    <= brush_x;
        y_q    <= brush_y;
        r_q    <= brush_radius;
        type_q <= brush_type;
      end
      if (state == ST_SETUP) begin
        x0_q <= x0;
        x1_q <= x1;
        y1_q <= y1;
        cx   <= x0;
        cy   <= y0;
`ifndef BRUSH_SQUARE_EN
        r2_q <= 16'(r_q) * 16'(r_q);
`endif
      end
      if (advance && !last_cell) begin
        if (cx == x1_q) begin
          cx <= x0_q;
          cy <= cy + 8'd1;
        end else begin
          cx <= cx + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sand_brush_painter.sv
// -----------------------------------------------------------------------------
// tb_sand_brush_painter
//
// Purpose:
//   Self-checking bench for sand_brush_painter. A table of brush commands with
//   hand-computed write counts, completion latencies and first/last write
//   addresses is applied in a loop, followed by hand-written sequences for a
//   start pulsed while busy and a reset in the middle of a scan.
//   Expected values follow BRUSH_SQUARE_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_sand_brush_painter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  brush_x, brush_y, brush_radius;
  logic [1:0]  brush_type;
  logic        busy, done, cell_we, cell_ready;
  logic [14:0] cell_addr;
  logic [1:0]  cell_data;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sand_brush_painter #(.GRID_W(160), .GRID_H(120), .ADDR_W(15)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .brush_x      (brush_x),
    .brush_y      (brush_y),
    .brush_radius (brush_radius),
    .brush_type   (brush_type),
    .busy         (busy),
    .done         (done),
    .cell_addr    (cell_addr),
    .cell_data    (cell_data),
    .cell_we      (cell_we),
    .cell_ready   (cell_ready)
  );

  typedef struct {
    int x;
    int y;
    int r;
    int typ;
    int stall;
    int expWrites;
    int expLat;
    int expFirst;
    int expLast;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one paint starting from idle. Latency is counted in cycles after the
  // edge that samples start, so the first visible cycle is 1 (setup).
  // busyStartAt / resetAt inject a start pulse or a reset at that cycle (0 = never).
  task automatic applyStimulus(input vec_t v, input int busyStartAt, input int resetAt,
                               output int writes, output int lat, output int first,
                               output int last, output int dataErrs, output int stableErrs);
    int stallLeft;
    bit holding;
    int heldAddr, heldData;
    writes = 0; first = -1; last = -1; dataErrs = 0; stableErrs = 0;
    stallLeft = v.stall; holding = 0; heldAddr = 0; heldData = 0;
    brush_x      = 8'(v.x);
    brush_y      = 8'(v.y);
    brush_radius = 8'(v.r);
    brush_type   = 2'(v.typ);
    cell_ready   = 1'b1;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    brush_x      = 8'($urandom_range(0, 255));
    brush_y      = 8'($urandom_range(0, 255));
    brush_radius = 8'($urandom_range(0, 255));
    brush_type   = 2'($urandom_range(0, 3));
    lat = 1;
    while (!done && lat < 300) begin
      start = 1'b0;
      if (lat == resetAt) begin
        reset = 1'b1;
        return;
      end
      if (lat == busyStartAt) begin
        start = 1'b1;
        brush_x = 8'd0; brush_y = 8'd0; brush_radius = 8'd5;
      end
      if (cell_we && stallLeft > 0) begin
        if (!holding) begin
          heldAddr = int'(cell_addr); heldData = int'(cell_data); holding = 1;
        end else if (int'(cell_addr) != heldAddr || int'(cell_data) != heldData) begin
          stableErrs++;
        end
        cell_ready = 1'b0;
        stallLeft--;
      end else begin
        if (holding && (!cell_we || int'(cell_addr) != heldAddr || int'(cell_data) != heldData))
          stableErrs++;
        holding = 0;
        cell_ready = 1'b1;
      end
      if (cell_we && cell_ready) begin
        writes++;
        if (first < 0) first = int'(cell_addr);
        last = int'(cell_addr);
        if (int'(cell_data) != v.typ) dataErrs++;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    cell_ready = 1'b1;
    if (!done) checkOutput("done_timeout", 0, 1);
  endtask

  initial begin
    int writes, lat, first, last, dataErrs, stableErrs;
    int doneSeen;

`ifdef BRUSH_SQUARE_EN
    vecs[0] = '{10, 20, 0, 2, 0,  1,  3,  3210,  3210};
    vecs[1] = '{50, 50, 2, 1, 0, 25, 27,  7728,  8372};
    vecs[2] = '{ 0,  0, 3, 3, 0, 16, 18,     0,   483};
    vecs[3] = '{10, 20, 0, 2, 5,  1,  8,  3210,  3210};
    vecs[4] = '{200, 30, 10, 1, 0, 0,  2,    -1,    -1};
    vecs[5] = '{159, 119, 1, 3, 0, 4,  6, 19038, 19199};
    vecs[6] = '{165, 10, 6, 2, 0, 13, 15,   799,  2719};
`else
    vecs[0] = '{10, 20, 0, 2, 0,  1,  3,  3210,  3210};
    vecs[1] = '{50, 50, 2, 1, 0, 13, 27,  7730,  8370};
    vecs[2] = '{ 0,  0, 3, 3, 0, 11, 18,     0,   480};
    vecs[3] = '{10, 20, 0, 2, 5,  1,  8,  3210,  3210};
    vecs[4] = '{200, 30, 10, 1, 0, 0,  2,    -1,    -1};
    vecs[5] = '{159, 119, 1, 3, 0, 3,  6, 19039, 19199};
    vecs[6] = '{165, 10, 6, 2, 0,  1, 15,  1759,  1759};
`endif

    reset = 1'b1; start = 1'b0; cell_ready = 1'b1;
    brush_x = 8'd0; brush_y = 8'd0; brush_radius = 8'd0; brush_type = 2'd0;
    repeat (3) tick();
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_we", int'(cell_we), 0);
    checkOutput("reset_addr", int'(cell_addr), 0);
    checkOutput("reset_data", int'(cell_data), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      $display("[TB] vector %0d: (%0d,%0d) r=%0d type=%0d stall=%0d",
               i, vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].typ, vecs[i].stall);
      applyStimulus(vecs[i], 0, 0, writes, lat, first, last, dataErrs, stableErrs);
      checkOutput($sformatf("v%0d_writes", i), writes, vecs[i].expWrites);
      checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].expLat);
      checkOutput($sformatf("v%0d_first_addr", i), first, vecs[i].expFirst);
      checkOutput($sformatf("v%0d_last_addr", i), last, vecs[i].expLast);
      checkOutput($sformatf("v%0d_data", i), dataErrs, 0);
      checkOutput($sformatf("v%0d_stall_stable", i), stableErrs, 0);
      tick();
      checkOutput($sformatf("v%0d_idle_after", i), int'(busy), 0);
    end

    // A start pulsed mid-scan must be ignored and must not queue a second paint.
    $display("[TB] start while busy");
    applyStimulus(vecs[1], 10, 0, writes, lat, first, last, dataErrs, stableErrs);
    checkOutput("busy_start_writes", writes, vecs[1].expWrites);
    checkOutput("busy_start_latency", lat, vecs[1].expLat);
    tick();
    checkOutput("busy_start_no_requeue_busy", int'(busy), 0);
    tick();
    checkOutput("busy_start_no_requeue_busy2", int'(busy), 0);

    // Reset on the sixth scan cycle: everything drops on the next edge, no done.
    $display("[TB] reset mid scan");
    applyStimulus(vecs[1], 0, 7, writes, lat, first, last, dataErrs, stableErrs);
    checkOutput("midreset_reached", lat, 7);
    tick();
    checkOutput("midreset_we", int'(cell_we), 0);
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_done", int'(done), 0);
    reset = 1'b0;
    doneSeen = 0;
    for (int c = 0; c < 30; c++) begin
      if (done || busy) doneSeen++;
      tick();
    end
    checkOutput("midreset_stays_idle", doneSeen, 0);

    // The design must still paint normally after the abort.
    applyStimulus(vecs[0], 0, 0, writes, lat, first, last, dataErrs, stableErrs);
    checkOutput("post_reset_writes", writes, vecs[0].expWrites);
    checkOutput("post_reset_addr", first, vecs[0].expFirst);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
